bank_request_router: RTL and testbench

Two-requester front end for the dual-bank byte memory. It accepts read/write requests from requesters A and B over valid/ready handshakes. It decodes the bank from the address MSB and arbitrates round-robin when both requesters target the same bank. It drives each bank's write_en/addr/data_in port and routes registered bank read data back to the requester that issued the read.

---
 rtl/bank_router_pkg.sv | 17 +
 rtl/bank_request_router_arbiter.sv | 20 ++
 rtl/bank_request_router.sv | 144 ++++++++++++++
 tb/tb_bank_request_router.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_router_pkg.sv
// Shared types and defaults for the dual-bank request router.
package bank_router_pkg;

   localparam int unsigned ADDR_W_DEF = 9;
   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_e;

   typedef struct packed {
      logic pending;
      req_e owner;
   } tag_t;

endpackage

// File: rtl/bank_request_router_arbiter.sv
// bank_rr_arbiter: two-requester grant for one bank, steered by an external
// round-robin priority so every bank shares the same fairness state.
module bank_rr_arbiter
   import bank_router_pkg::*;
(
   input  logic req_a,
   input  logic req_b,
   input  req_e prio,
   output logic grant_a,
   output logic grant_b,
   output logic conflict
);

   always_comb begin
      conflict = req_a & req_b;
      grant_a  = req_a & (~req_b | (prio == REQ_A));
      grant_b  = req_b & (~req_a | (prio == REQ_B));
   end

endmodule

// File: rtl/bank_request_router.sv
// Two-requester front end for the dual-bank byte memory: bank decode,
// round-robin arbitration, bank drive and read-response routing.
// Optional conflict counter enabled by defining BANK_ROUTER_STATS_EN.
module bank_request_router
   import bank_router_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
`ifdef BANK_ROUTER_STATS_EN
   , parameter int unsigned STAT_W = 16
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              bank0_write_en,
   output logic [ADDR_W-2:0] bank0_addr,
   output logic [DATA_W-1:0] bank0_data_in,
   input  logic [DATA_W-1:0] bank0_data_out,
   output logic              bank1_write_en,
   output logic [ADDR_W-2:0] bank1_addr,
   output logic [DATA_W-1:0] bank1_data_in,
   input  logic [DATA_W-1:0] bank1_data_out
`ifdef BANK_ROUTER_STATS_EN
   , output logic [STAT_W-1:0] conflict_cnt
`endif
);

   localparam int unsigned BA_W = ADDR_W - 1;

   req_e              rr_prio;
   logic [1:0]        req_a, req_b, grant_a, grant_b, conflict, issue, we_n;
   logic [BA_W-1:0]   addr_n [2];
   logic [BA_W-1:0]   addr_q [2];
   logic [DATA_W-1:0] din_n  [2];
   logic [DATA_W-1:0] data_q [2];
   logic [DATA_W-1:0] dout   [2];
   tag_t              tag_q  [2];

   assign req_a = {a_valid & a_addr[ADDR_W-1], a_valid & ~a_addr[ADDR_W-1]} & {2{~rst}};
   assign req_b = {b_valid & b_addr[ADDR_W-1], b_valid & ~b_addr[ADDR_W-1]} & {2{~rst}};

   // A single rr_prio feeds both banks; at most one bank can conflict per cycle.
   bank_rr_arbiter u_arb0 (
      .req_a    (req_a[0]),
      .req_b    (req_b[0]),
      .prio     (rr_prio),
      .grant_a  (grant_a[0]),
      .grant_b  (grant_b[0]),
      .conflict (conflict[0])
   );

   bank_rr_arbiter u_arb1 (
      .req_a    (req_a[1]),
      .req_b    (req_b[1]),
      .prio     (rr_prio),
      .grant_a  (grant_a[1]),
      .grant_b  (grant_b[1]),
      .conflict (conflict[1])
   );

   assign a_ready = |grant_a;
   assign b_ready = |grant_b;
   assign issue   = grant_a | grant_b;
   assign dout[0] = bank0_data_out;
   assign dout[1] = bank1_data_out;

   // Idle banks replay the last driven addr/data from the hold registers.
   always_comb begin
      for (int unsigned n = 0; n < 2; n++) begin
         we_n[n]   = issue[n] & (grant_b[n] ? b_we : a_we);
         addr_n[n] = issue[n] ? (grant_b[n] ? b_addr[BA_W-1:0] : a_addr[BA_W-1:0]) : addr_q[n];
         din_n[n]  = we_n[n] ? (grant_b[n] ? b_wdata : a_wdata) : data_q[n];
      end
   end

   assign bank0_write_en = we_n[0];
   assign bank0_addr     = addr_n[0];
   assign bank0_data_in  = din_n[0];
   assign bank1_write_en = we_n[1];
   assign bank1_addr     = addr_n[1];
   assign bank1_data_in  = din_n[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_prio <= REQ_A;
         for (int unsigned n = 0; n < 2; n++) begin
            addr_q[n] <= '0;
            data_q[n] <= '0;
            tag_q[n]  <= '{pending: 1'b0, owner: REQ_A};
         end
      end else begin
         if (|conflict)
            rr_prio <= (rr_prio == REQ_A) ? REQ_B : REQ_A;
         for (int unsigned n = 0; n < 2; n++) begin
            if (issue[n])
               addr_q[n] <= addr_n[n];
            if (we_n[n])
               data_q[n] <= din_n[n];
            tag_q[n] <= '{pending: issue[n] & ~we_n[n], owner: grant_b[n] ? REQ_B : REQ_A};
         end
      end
   end

   always_comb begin
      a_rvalid = 1'b0;
      a_rdata  = '0;
      b_rvalid = 1'b0;
      b_rdata  = '0;
      for (int unsigned n = 0; n < 2; n++) begin
         if (tag_q[n].pending && tag_q[n].owner == REQ_A) begin
            a_rvalid = 1'b1;
            a_rdata  = dout[n];
         end
         if (tag_q[n].pending && tag_q[n].owner == REQ_B) begin
            b_rvalid = 1'b1;
            b_rdata  = dout[n];
         end
      end
   end

`ifdef BANK_ROUTER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         conflict_cnt <= '0;
      else if (|conflict && conflict_cnt != '1)
         conflict_cnt <= conflict_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_bank_request_router.sv
// Randomized scoreboard bench for bank_request_router with a byte-memory
// model attached to both bank ports.
module tb_bank_request_router;

   typedef struct {
      bit       v;
      bit       we;
      bit [8:0] addr;
      bit [7:0] wd;
   } req_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_valid = 0, a_we = 0, b_valid = 0, b_we = 0;
   logic [8:0] a_addr = '0, b_addr = '0;
   logic [7:0] a_wdata = '0, b_wdata = '0;
   logic       a_ready, b_ready, a_rvalid, b_rvalid;
   logic [7:0] a_rdata, b_rdata;
   logic       bank0_write_en, bank1_write_en;
   logic [7:0] bank0_addr, bank1_addr;
   logic [7:0] bank0_data_in, bank1_data_in;
   logic [7:0] bank0_data_out = '0, bank1_data_out = '0;
`ifdef BANK_ROUTER_STATS_EN
   logic [15:0] conflict_cnt;
`endif

   bank_request_router #(.ADDR_W(9), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .bank0_write_en(bank0_write_en), .bank0_addr(bank0_addr),
      .bank0_data_in(bank0_data_in), .bank0_data_out(bank0_data_out),
      .bank1_write_en(bank1_write_en), .bank1_addr(bank1_addr),
      .bank1_data_in(bank1_data_in), .bank1_data_out(bank1_data_out)
`ifdef BANK_ROUTER_STATS_EN
      , .conflict_cnt(conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] init_val(input int i);
      return 8'(i * 7 + 3);
   endfunction

   // Byte memory: bank ports captured mid-cycle, applied at the rising edge.
   logic [7:0] tmem0 [256];
   logic [7:0] tmem1 [256];
   initial begin
      logic       we0, we1;
      logic [7:0] ad0, ad1, di0, di1;
      we0 = 0; we1 = 0; ad0 = 0; ad1 = 0; di0 = 0; di1 = 0;
      for (int i = 0; i < 256; i++) begin
         tmem0[i] = init_val(i);
         tmem1[i] = init_val(256 + i);
      end
      forever begin
         @(negedge clk);
         we0 = bank0_write_en; ad0 = bank0_addr; di0 = bank0_data_in;
         we1 = bank1_write_en; ad1 = bank1_addr; di1 = bank1_data_in;
         @(posedge clk);
         bank0_data_out <= tmem0[ad0];
         bank1_data_out <= tmem1[ad1];
         if (we0) tmem0[ad0] = di0;
         if (we1) tmem1[ad1] = di1;
      end
   end

   // Reference model: flat 512-byte array, favoured requester, bank hold values.
   logic [7:0] ref_mem [512];
   bit         fav_b;
   logic [7:0] last_addr [2];
   logic [7:0] last_data [2];
   int         conf_m;
   exp_t       qa[$], qb[$];

   task automatic model_reset();
      fav_b = 0;
      conf_m = 0;
      for (int n = 0; n < 2; n++) begin
         last_addr[n] = '0;
         last_data[n] = '0;
      end
      qa.delete();
      qb.delete();
   endtask

   initial begin
      exp_t e;
      bit   ea, eb;
      forever begin
         @(negedge clk);
         ea = qa.size() > 0 && qa[0].cyc == cyc;
         chk("a_rvalid", a_rvalid, ea);
         if (ea) begin
            e = qa.pop_front();
            chk("a_rdata", a_rdata, e.data);
         end
         eb = qb.size() > 0 && qb[0].cyc == cyc;
         chk("b_rvalid", b_rvalid, eb);
         if (eb) begin
            e = qb.pop_front();
            chk("b_rdata", b_rdata, e.data);
         end
      end
   end

   task automatic do_cycle(input req_t ra, input req_t rb, output bit acc_a, output bit acc_b);
      bit         same;
      bit         wen [2];
      logic [7:0] dat [2];
      @(posedge clk);
      #1;
      rst = 0;
      a_valid = ra.v; a_we = ra.we; a_addr = ra.addr; a_wdata = ra.wd;
      b_valid = rb.v; b_we = rb.we; b_addr = rb.addr; b_wdata = rb.wd;
      @(negedge clk);
      same  = ra.v && rb.v && ra.addr[8] == rb.addr[8];
      acc_a = ra.v && (!same || !fav_b);
      acc_b = rb.v && (!same || fav_b);
      if (same) begin
         fav_b = !fav_b;
         if (conf_m < 65535) conf_m++;
      end
      chk("a_ready", a_ready, acc_a);
      chk("b_ready", b_ready, acc_b);
      wen[0] = 0; wen[1] = 0;
      if (acc_a) begin
         last_addr[ra.addr[8]] = ra.addr[7:0];
         if (ra.we) begin
            wen[ra.addr[8]] = 1;
            last_data[ra.addr[8]] = ra.wd;
            ref_mem[ra.addr] = ra.wd;
         end else qa.push_back('{ref_mem[ra.addr], cyc + 1});
      end
      if (acc_b) begin
         last_addr[rb.addr[8]] = rb.addr[7:0];
         if (rb.we) begin
            wen[rb.addr[8]] = 1;
            last_data[rb.addr[8]] = rb.wd;
            ref_mem[rb.addr] = rb.wd;
         end else qb.push_back('{ref_mem[rb.addr], cyc + 1});
      end
      dat[0] = bank0_data_in;
      dat[1] = bank1_data_in;
      chk("bank0_write_en", bank0_write_en, wen[0]);
      chk("bank1_write_en", bank1_write_en, wen[1]);
      chk("bank0_addr", bank0_addr, last_addr[0]);
      chk("bank1_addr", bank1_addr, last_addr[1]);
      chk("bank0_data_in", dat[0], last_data[0]);
      chk("bank1_data_in", dat[1], last_data[1]);
`ifdef BANK_ROUTER_STATS_EN
      chk("conflict_cnt", conflict_cnt, conf_m);
`endif
   endtask

   task automatic reset_phase();
      @(posedge clk);
      #1;
      rst = 1;
      a_valid = 1; a_we = 0; a_addr = 9'h003;
      b_valid = 0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_a_ready", a_ready, 0);
         chk("rst_b_ready", b_ready, 0);
         chk("rst_bank0_write_en", bank0_write_en, 0);
         chk("rst_bank1_write_en", bank1_write_en, 0);
         chk("rst_bank0_addr", bank0_addr, 0);
         chk("rst_bank1_addr", bank1_addr, 0);
         chk("rst_bank0_data_in", bank0_data_in, 0);
         chk("rst_a_rdata", a_rdata, 0);
`ifdef BANK_ROUTER_STATS_EN
         chk("rst_conflict_cnt", conflict_cnt, 0);
`endif
         if (i < 2) @(posedge clk);
      end
   endtask

   function automatic req_t mk(input bit v, input bit we, input int addr, input int wd);
      req_t r;
      r.v = v; r.we = we; r.addr = 9'(addr); r.wd = 8'(wd);
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.v    = $urandom_range(0, 3) != 0;
      r.we   = 1'($urandom_range(0, 1));
      r.addr = {1'($urandom_range(0, 1)), 8'($urandom_range(0, 15))};
      r.wd   = 8'($urandom);
      return r;
   endfunction

   initial begin
      req_t idle, pa, pb;
      bit   ka, kb;
      idle = mk(0, 0, 0, 0);
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      reset_phase();

      do_cycle(mk(1, 1, 'h005, 'h3C), idle, ka, kb);
      do_cycle(idle, mk(1, 0, 'h005, 0), ka, kb);
      do_cycle(mk(1, 1, 'h1FF, 'hA5), mk(1, 1, 'h0FF, 'h5A), ka, kb);
      do_cycle(mk(1, 0, 'h1FF, 0), mk(1, 0, 'h0FF, 0), ka, kb);
      for (int i = 0; i < 4; i++)
         do_cycle(mk(1, 0, 'h100 + i, 0), mk(1, 0, 'h180 + i, 0), ka, kb);
      do_cycle(mk(1, 0, 'h010, 0), mk(1, 0, 'h110, 0), ka, kb);
      do_cycle(idle, idle, ka, kb);

      do_cycle(mk(1, 0, 'h020, 0), idle, ka, kb);
      reset_phase();
      do_cycle(mk(1, 0, 'h130, 0), mk(1, 0, 'h131, 0), ka, kb);
      do_cycle(idle, idle, ka, kb);

      pa = idle; pb = idle; ka = 0; kb = 0;
      for (int i = 0; i < 1500; i++) begin
         if (!pa.v || ka) pa = rand_req();
         if (!pb.v || kb) pb = rand_req();
         do_cycle(pa, pb, ka, kb);
      end
      do_cycle(idle, idle, ka, kb);
      do_cycle(idle, idle, ka, kb);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not complete, got %0d cycles, expected fewer", cyc);
      $fatal(1);
   end

endmodule
